shift_normalizer: RTL and testbench

- Multi-cycle normalizer that computes the inverse of the datapath barrel shifter.
- Given a 32-bit word, it finds the left-shift amount that normalizes it and returns the shifted word plus that amount.
- Feeding data_out and shift_out back into the barrel shifter as a right shift, with the same arithmetic mode, reconstructs data_in.
- Sits beside the ALU shifter and serves normalization, count-leading-zeros and count-redundant-sign-bits operations through a valid/ready handshake.

---
 rtl/shift_normalizer_pkg.sv | 18 +
 rtl/shift_normalizer_if.sv | 35 +++
 rtl/shift_normalizer_norm_stage.sv | 50 +++++
 rtl/shift_normalizer.sv | 126 ++++++++++++
 tb/tb_shift_normalizer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/shift_normalizer_pkg.sv
// ---------------------------------------------------------------------------
// shift_normalizer_pkg
//   Shared definitions for the shift normalizer: default datapath widths and
//   the FSM state encoding used by the top module.
// ---------------------------------------------------------------------------
package shift_normalizer_pkg;

   // Default datapath width (power of two) and matching shift-amount width.
   localparam int DATA_W_DEF  = 32;
   localparam int SHIFT_W_DEF = $clog2(DATA_W_DEF);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/shift_normalizer_if.sv
// ---------------------------------------------------------------------------
// shift_normalizer_if
//   Request/response handshake bundle for the shift normalizer.
//   Request  : in_valid, in_ready, data_in, arithmetic
//   Response : out_valid, out_ready, data_out, shift_out, zero
//   Modports : master = requester/consumer side, slave = normalizer side.
// ---------------------------------------------------------------------------
interface shift_normalizer_if
   import shift_normalizer_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF
);

   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  data_in;
   logic               arithmetic;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  data_out;
   logic [SHIFT_W-1:0] shift_out;
   logic               zero;

   modport master (
      output in_valid, data_in, arithmetic, out_ready,
      input  in_ready, out_valid, data_out, shift_out, zero
   );

   modport slave (
      input  in_valid, data_in, arithmetic, out_ready,
      output in_ready, out_valid, data_out, shift_out, zero
   );

endinterface

// File: rtl/shift_normalizer_norm_stage.sv
// ---------------------------------------------------------------------------
// norm_stage
//   One binary-search step of the normalizer. For step k (w = 2^k) it tests
//   whether the top bits of the working word are redundant and, if so,
//   shifts them out.
//   i_work : current working word
//   i_step : search step k
//   i_mode : 0 = leading zeros, 1 = redundant sign bits
//   o_work : working word after this step
//   o_inc  : amount to add to the running shift count (w or 0)
// ---------------------------------------------------------------------------
module norm_stage
   import shift_normalizer_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF,
   parameter int STEP_W  = $clog2(SHIFT_W)
) (
   input  logic [DATA_W-1:0]  i_work,
   input  logic [STEP_W-1:0]  i_step,
   input  logic               i_mode,
   output logic [DATA_W-1:0]  o_work,
   output logic [SHIFT_W-1:0] o_inc
);

   logic [SHIFT_W-1:0] w_width;
   logic [DATA_W-1:0]  w_top_mask;   // top w bits
   logic [DATA_W-1:0]  w_sign_mask;  // top w+1 bits (sign bit plus w copies)
   logic [DATA_W-1:0]  w_field;
   logic               w_redundant;

   // NOTE: every output of a combinational block is assigned on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      w_width     = SHIFT_W'(1) << i_step;
      w_top_mask  = ~({DATA_W{1'b1}} >> w_width);
      w_sign_mask = ~({DATA_W{1'b1}} >> (w_width + SHIFT_W'(1)));
      if (i_mode) begin
         // Sign bit plus the next w bits all equal: those w bits are redundant.
         w_field     = i_work & w_sign_mask;
         w_redundant = (w_field == '0) || (w_field == w_sign_mask);
      end else begin
         w_field     = i_work & w_top_mask;
         w_redundant = (w_field == '0);
      end
      o_work = w_redundant ? (i_work << w_width) : i_work;
      o_inc  = w_redundant ? w_width : '0;
   end

endmodule

// File: rtl/shift_normalizer.sv
// ---------------------------------------------------------------------------
// shift_normalizer
//   Multi-cycle normalizer: finds the left shift that normalizes a word
//   (count leading zeros or count redundant sign bits) using a binary search,
//   one step per cycle, then returns the shifted word and the shift amount.
//   Right-shifting data_out by shift_out in the same mode rebuilds data_in.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : shift_normalizer_if.slave (valid/ready request and response)
// ---------------------------------------------------------------------------
module shift_normalizer
   import shift_normalizer_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   shift_normalizer_if.slave  bus
);

   localparam int STEP_W = $clog2(SHIFT_W);

   state_t             r_state;
   state_t             w_next_state;
   logic [DATA_W-1:0]  r_work;
   logic               r_mode;
   logic [SHIFT_W-1:0] r_cnt;
   logic [STEP_W-1:0]  r_step;
   logic [DATA_W-1:0]  r_data_out;
   logic [SHIFT_W-1:0] r_shift_out;
   logic               r_zero;

   logic [DATA_W-1:0]  w_next_work;
   logic [SHIFT_W-1:0] w_inc;
   logic [SHIFT_W-1:0] w_cnt_sum;
   logic               w_accept;
   logic               w_last_step;

   norm_stage #(
      .DATA_W  (DATA_W),
      .SHIFT_W (SHIFT_W),
      .STEP_W  (STEP_W)
   ) u_norm_stage (
      .i_work (r_work),
      .i_step (r_step),
      .i_mode (r_mode),
      .o_work (w_next_work),
      .o_inc  (w_inc)
   );

   assign w_cnt_sum   = r_cnt + w_inc;
   assign w_last_step = (r_step == '0);
   assign w_accept    = bus.in_valid && bus.in_ready;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential blocks use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_accept)      w_next_state = S_SEARCH;
         S_SEARCH: if (w_last_step)   w_next_state = S_DONE;
         S_DONE:   if (bus.out_ready) w_next_state = S_IDLE;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Requests are only taken in IDLE; DONE always releases to IDLE first,
   // so there is no same-cycle turnaround.
   always_comb begin
      bus.in_ready  = (r_state == S_IDLE);
      bus.out_valid = (r_state == S_DONE);
   end

   assign bus.data_out  = r_data_out;
   assign bus.shift_out = r_shift_out;
   assign bus.zero      = r_zero;

   // ---------------- Datapath ----------------
   // NOTE: the working registers are reset too; the block holds no memory
   // arrays, so clearing everything costs nothing and keeps outputs defined.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work      <= '0;
         r_mode      <= 1'b0;
         r_cnt       <= '0;
         r_step      <= '0;
         r_data_out  <= '0;
         r_shift_out <= '0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_work <= bus.data_in;
                  r_mode <= bus.arithmetic;
                  r_zero <= (bus.data_in == '0);
                  r_cnt  <= '0;
                  r_step <= STEP_W'(SHIFT_W - 1);
               end
            end
            S_SEARCH: begin
               r_work <= w_next_work;
               r_cnt  <= w_cnt_sum;
               r_step <= r_step - STEP_W'(1);
               // Results load straight from the last step so they appear
               // together with out_valid and stay put through DONE.
               if (w_last_step) begin
                  r_data_out  <= w_next_work;
                  r_shift_out <= w_cnt_sum;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
// ---------------------------------------------------------------------------
// tb_shift_normalizer
//   Self-checking bench for shift_normalizer: directed corner cases,
//   backpressure, mid-search reset and randomized requests compared against
//   a bit-counting reference model.
// ---------------------------------------------------------------------------
module tb_shift_normalizer;
   import shift_normalizer_pkg::*;

   logic clk = 1'b0;
   logic rst;

   shift_normalizer_if bus ();

   shift_normalizer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference: count leading zeros / redundant sign bits bit by bit.
   function automatic void model(input logic [31:0] d, input logic arith,
                                 output logic [31:0] exp_data, output logic [4:0] exp_shift);
      int n = 0;
      if (!arith) while (n < 31 && d[31-n] == 1'b0) n++;
      else        while (n < 31 && d[30-n] == d[31]) n++;
      exp_data  = d << n;
      exp_shift = 5'(n);
   endfunction

   // Present a request in IDLE and let it be accepted on the next edge.
   task automatic issue(input logic [31:0] d, input logic a);
      bus.in_valid   = 1'b1;
      bus.data_in    = d;
      bus.arithmetic = a;
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid   = 1'b0;
      bus.data_in    = $urandom;   // must be ignored after acceptance
      bus.arithmetic = ~a;
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
   endtask

   // Wait (bounded) for out_valid and check latency and result.
   task automatic result(input logic [31:0] d, input logic a);
      logic [31:0] ed;
      logic [4:0]  es;
      logic [31:0] rec;
      int          lat = 1;
      model(d, a, ed, es);
      @(posedge clk); #1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'd5);
      check("data_out", bus.data_out, ed);
      check("shift_out", 32'(bus.shift_out), 32'(es));
      check("zero", 32'(bus.zero), 32'(d == 32'd0));
      if (a) rec = $signed(bus.data_out) >>> bus.shift_out;
      else   rec = bus.data_out >> bus.shift_out;
      check("reconstruct", rec, d);
   endtask

   // Hold the result for a few cycles, then consume it.
   task automatic release_result(input int hold);
      logic [31:0] held_data = bus.data_out;
      logic [4:0]  held_shift = bus.shift_out;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_data", bus.data_out, held_data);
         check("hold_shift", 32'(bus.shift_out), 32'(held_shift));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_drop", 32'(bus.out_valid), 32'd0);
      check("in_ready_back", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_op(input logic [31:0] d, input logic a, input int hold);
      issue(d, a);
      result(d, a);
      release_result(hold);
   endtask

   logic [31:0] dir_data [8] = '{32'h0000_1234, 32'hFFFF_F000, 32'h0000_00FF, 32'h0000_0000,
                                 32'hFFFF_FFFF, 32'h8000_0001, 32'h4000_0000, 32'h0000_0000};
   logic        dir_mode [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.data_in    = '0;
      bus.arithmetic = 1'b0;
      bus.out_ready  = 1'b0;
      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data_out", bus.data_out, 32'd0);
      check("rst_shift_out", 32'(bus.shift_out), 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed corner cases with known answers.
      for (int i = 0; i < 8; i++) run_op(dir_data[i], dir_mode[i], 0);

      // Backpressure with a competing request that must not be queued.
      issue(32'h0000_1234, 1'b0);
      result(32'h0000_1234, 1'b0);
      bus.in_valid   = 1'b1;
      bus.data_in    = 32'h0000_0001;
      bus.arithmetic = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_data", bus.data_out, 32'h91A0_0000);
         check("bp_shift", 32'(bus.shift_out), 32'd19);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_release_valid", 32'(bus.out_valid), 32'd0);
      check("bp_release_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("bp_accepted", 32'(bus.in_ready), 32'd0);
      result(32'h0000_0001, 1'b0);
      check("bp_one_data", bus.data_out, 32'h8000_0000);
      check("bp_one_shift", 32'(bus.shift_out), 32'd31);
      release_result(0);

      // Reset on the third SEARCH cycle abandons the transaction.
      issue(32'h0000_1234, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_data", bus.data_out, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("post_rst_valid", 32'(bus.out_valid), 32'd0);
         check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      end
      run_op(32'h0001_0000, 1'b0, 0);
      check("post_rst_shift", 32'(bus.shift_out), 32'd15);

      // Randomized requests spread over the whole range of shift amounts.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] d;
         logic        a;
         a = 1'($urandom_range(0, 1));
         d = $urandom >> $urandom_range(0, 31);
         if (a && $urandom_range(0, 1) == 1) d = ~d;
         run_op(d, a, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
